mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported memory between the pipeline's instruction-fetch stage and its data-memory stage. It grants one access at a time and drives a variable-latency req/ack memory handshake. It returns read data and a done pulse to each requester. It also exports per-stage stall signals, which the pipeline hazard logic ORs into its existing stall/flush terms.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: fetch port, data port, memory port and stalls.
// slave = arbiter view; master = requesters/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_flush;
    logic          i_done;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  i_req, i_addr, i_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ack, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr, i_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ack, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported req/ack memory between the fetch and data stages,
// one access at a time, round-robin when both ask in the same cycle.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic          abort_q, abort_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          i_elig, d_elig, pick_d;

    // A requester still holding req during its done cycle is not re-granted.
    assign i_elig = bus.i_req && !i_done_q;
    assign d_elig = bus.d_req && !d_done_q;
    assign pick_d = d_elig && (!i_elig || !last_d_q);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d   = state_q;
        last_d_d  = last_d_q;
        abort_d   = abort_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                    abort_d  = 1'b0;
                    we_d     = bus.d_we;
                    addr_d   = bus.d_addr;
                    wdata_d  = bus.d_wdata;
                end else if (i_elig) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                    abort_d  = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = bus.i_addr;
                end
            end
            BUSY_I: begin
                if (bus.i_flush) begin
                    abort_d = 1'b1;
                end
                // A flush landing in the ack cycle drops the completion as well.
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    abort_d = 1'b0;
                    if (!abort_q && !bus.i_flush) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    state_d  = IDLE;
                    d_done_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            abort_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            abort_q   <= abort_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // mem_req decodes straight from state so an async reset drops it immediately.
    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.i_req && !i_done_q;
    assign bus.stall_mem = bus.d_req && !d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// (word memory array, round-robin grant rule, per-requester outstanding flags).
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_i_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;

    // Move to the next cycle: inputs are driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_done, bus.d_done, bus.i_rdata, bus.d_rdata} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%0h required=0", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_done, bus.d_done, bus.i_rdata, bus.d_rdata});
        end
        bus.i_req = 1'b1; bus.d_req = 1'b1; #1;
        checks++; if ({bus.stall_if, bus.stall_mem} !== 2'b11) begin
            failures++; $display("FAIL reset_stall_follow got=%b required=11", {bus.stall_if, bus.stall_mem});
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0; #1;
        checks++; if ({bus.stall_if, bus.stall_mem} !== 2'b00) begin
            failures++; $display("FAIL reset_stall_low got=%b required=00", {bus.stall_if, bus.stall_mem});
        end
        tick();
        rst_n = 1'b1;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    task automatic test_single_fetch();
        tick(); bus.i_req = 1'b1; bus.i_addr = 32'h40;
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.stall_if} !== 2'b01) begin
            failures++; $display("FAIL fetch_c0 req/stall got=%b required=01", {bus.mem_req, bus.stall_if});
        end
        tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8C010004;
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_done, bus.stall_if} !== {1'b1, 1'b0, 32'h40, 1'b0, 1'b1}) begin
            failures++; $display("FAIL fetch_c1 bus got=%0h required=%0h", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_done, bus.stall_if}, {1'b1, 1'b0, 32'h40, 1'b0, 1'b1});
        end
        tick(); bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        exp_i_rdata = 32'h8C010004;
        checks++; if ({bus.mem_req, bus.i_done, bus.d_done, bus.stall_if} !== 4'b0100) begin
            failures++; $display("FAIL fetch_c2 req/idone/ddone/stall got=%b required=0100", {bus.mem_req, bus.i_done, bus.d_done, bus.stall_if});
        end
        checks++; if (bus.i_rdata !== exp_i_rdata) begin
            failures++; $display("FAIL fetch_rdata got=%0h required=%0h", bus.i_rdata, exp_i_rdata);
        end
        tick(); bus.i_req = 1'b0;
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.i_done} !== 2'b00) begin
            failures++; $display("FAIL fetch_c3 pulse_width got=%b required=00", {bus.mem_req, bus.i_done});
        end
    endtask

    task automatic test_store_wait3();
        tick(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.stall_mem} !== 2'b01) begin
            failures++; $display("FAIL store_c0 req/stall got=%b required=01", {bus.mem_req, bus.stall_mem});
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) begin bus.d_addr = 32'h999; bus.d_wdata = 32'h0; bus.d_we = 1'b0; end
            if (c == 4) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D; end
            @(negedge clk);
            checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.d_done} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0}) begin
                failures++; $display("FAIL store_busy_c%0d got=%0h required=%0h", c, {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.d_done}, {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0});
            end
        end
        tick(); bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.d_done, bus.i_done, bus.stall_mem} !== 4'b0100) begin
            failures++; $display("FAIL store_c5 req/ddone/idone/stall got=%b required=0100", {bus.mem_req, bus.d_done, bus.i_done, bus.stall_mem});
        end
        checks++; if (bus.d_rdata !== exp_d_rdata) begin
            failures++; $display("FAIL store_d_rdata got=%0h required=%0h", bus.d_rdata, exp_d_rdata);
        end
        tick(); bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.d_done !== 1'b0) begin
            failures++; $display("FAIL store_c6 d_done got=%b required=0", bus.d_done);
        end
    endtask

    task automatic test_simultaneous();
        logic          er, eid, edd;
        logic [AW-1:0] ea;
        test_reset();
        tick(); bus.i_req = 1'b1; bus.i_addr = 32'h200; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        for (int c = 1; c <= 7; c++) begin
            tick();
            bus.mem_ack = bus.mem_req;
            bus.mem_rdata = 32'hA0000000 + c;
            if (c == 5) bus.i_req = 1'b0;
            if (c == 7) bus.d_req = 1'b0;
            er  = (c == 1 || c == 3 || c == 5);
            ea  = (c == 3) ? 32'h200 : 32'h300;
            eid = (c == 4);
            edd = (c == 2 || c == 6);
            if (c == 2) exp_d_rdata = 32'hA0000001;
            if (c == 4) exp_i_rdata = 32'hA0000003;
            if (c == 6) exp_d_rdata = 32'hA0000005;
            @(negedge clk);
            checks++; if ({bus.mem_req, bus.i_done, bus.d_done} !== {er, eid, edd}) begin
                failures++; $display("FAIL rr_c%0d req/idone/ddone got=%b required=%b", c, {bus.mem_req, bus.i_done, bus.d_done}, {er, eid, edd});
            end
            if (er) begin
                checks++; if (bus.mem_addr !== ea) begin
                    failures++; $display("FAIL rr_c%0d grant_addr got=%0h required=%0h", c, bus.mem_addr, ea);
                end
            end
            checks++; if ({bus.i_rdata, bus.d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
                failures++; $display("FAIL rr_c%0d rdata got=%0h required=%0h", c, {bus.i_rdata, bus.d_rdata}, {exp_i_rdata, exp_d_rdata});
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_flush();
        tick(); bus.i_req = 1'b1; bus.i_addr = 32'h80;
        tick();
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h80}) begin
            failures++; $display("FAIL flush_grant got=%0h required=%0h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h80});
        end
        tick(); bus.i_flush = 1'b1; bus.i_req = 1'b0;
        tick(); bus.i_flush = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234;
        tick(); bus.mem_ack = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h90;
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.i_done} !== 2'b00) begin
            failures++; $display("FAIL flush_no_done got=%b required=00", {bus.mem_req, bus.i_done});
        end
        checks++; if (bus.i_rdata !== exp_i_rdata) begin
            failures++; $display("FAIL flush_rdata_kept got=%0h required=%0h", bus.i_rdata, exp_i_rdata);
        end
        tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55550090;
        @(negedge clk);
        checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h90}) begin
            failures++; $display("FAIL flush_next_grant got=%0h required=%0h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h90});
        end
        tick(); bus.mem_ack = 1'b0; exp_i_rdata = 32'h55550090;
        @(negedge clk);
        checks++; if ({bus.i_done, bus.i_rdata} !== {1'b1, exp_i_rdata}) begin
            failures++; $display("FAIL flush_next_done got=%0h required=%0h", {bus.i_done, bus.i_rdata}, {1'b1, exp_i_rdata});
        end
        // Flush coinciding with a zero-wait ack.
        tick(); bus.i_addr = 32'hA0;
        tick(); bus.i_flush = 1'b1; bus.i_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD0BAD;
        tick(); bus.i_flush = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++; if ({bus.i_done, bus.i_rdata} !== {1'b0, exp_i_rdata}) begin
            failures++; $display("FAIL flush_in_ack got=%0h required=%0h", {bus.i_done, bus.i_rdata}, {1'b0, exp_i_rdata});
        end
    endtask

    task automatic test_reset_mid();
        tick(); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        tick();
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1) begin
            failures++; $display("FAIL rmid_busy mem_req got=%b required=1", bus.mem_req);
        end
        tick(); #2; rst_n = 1'b0; #1;
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_done, bus.d_done, bus.i_rdata, bus.d_rdata} !== '0) begin
            failures++; $display("FAIL rmid_outputs got=%0h required=0", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_done, bus.d_done, bus.i_rdata, bus.d_rdata});
        end
        exp_i_rdata = '0; exp_d_rdata = '0;
        bus.d_req = 1'b0;
        tick(); rst_n = 1'b1;
        tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h777;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL rmid_late_ack mem_req got=%b required=0", bus.mem_req);
        end
        tick(); bus.mem_ack = 1'b0;
        @(negedge clk);
        checks++; if ({bus.d_done, bus.i_done, bus.mem_req, bus.d_rdata} !== {3'b000, exp_d_rdata}) begin
            failures++; $display("FAIL rmid_no_done got=%0h required=%0h", {bus.d_done, bus.i_done, bus.mem_req, bus.d_rdata}, {3'b000, exp_d_rdata});
        end
    endtask

    task automatic test_stray_ack();
        tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD;
        tick(); bus.mem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if ({bus.mem_req, bus.i_done, bus.d_done, bus.i_rdata, bus.d_rdata} !== {3'b000, exp_i_rdata, exp_d_rdata}) begin
                failures++; $display("FAIL stray_ack_c%0d got=%0h required=%0h", c, {bus.mem_req, bus.i_done, bus.d_done, bus.i_rdata, bus.d_rdata}, {3'b000, exp_i_rdata, exp_d_rdata});
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] mem_model [16];
        logic [AW-1:0] cur_addr, p_i_addr, p_d_addr;
        logic [DW-1:0] cur_wdata, p_d_wdata;
        logic          cur_valid, cur_d, cur_we, cur_abort, p_d_we;
        logic          i_pend, d_pend, p_i_elig, p_d_elig, last_grant_d;
        logic          exp_req, exp_id, exp_dd, now_id, now_dd, flush, abandon;
        int            wait_left, n;
        for (int k = 0; k < 16; k++) mem_model[k] = $urandom;
        cur_addr = '0; cur_wdata = '0; p_i_addr = '0; p_d_addr = '0; p_d_wdata = '0;
        cur_valid = 0; cur_d = 0; cur_we = 0; cur_abort = 0; p_d_we = 0;
        i_pend = 0; d_pend = 0; p_i_elig = 0; p_d_elig = 0; last_grant_d = 0;
        exp_req = 0; exp_id = 0; exp_dd = 0; wait_left = 0; n = 0;
        while ((n < 600 || i_pend || d_pend || cur_valid) && n < 800) begin
            tick();
            now_id = exp_id; now_dd = exp_dd; exp_id = 0; exp_dd = 0;
            checks++; if ({bus.mem_req, bus.i_done, bus.d_done} !== {exp_req, now_id, now_dd}) begin
                failures++; $display("FAIL rnd_n%0d req/idone/ddone got=%b required=%b", n, {bus.mem_req, bus.i_done, bus.d_done}, {exp_req, now_id, now_dd});
            end
            checks++; if ({bus.i_rdata, bus.d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
                failures++; $display("FAIL rnd_n%0d rdata got=%0h required=%0h", n, {bus.i_rdata, bus.d_rdata}, {exp_i_rdata, exp_d_rdata});
            end
            if (now_id) i_pend = 0;
            if (now_dd) d_pend = 0;
            if (exp_req && !cur_valid) begin
                cur_d = p_d_elig && (!p_i_elig || !last_grant_d);
                last_grant_d = cur_d;
                cur_addr = cur_d ? p_d_addr : p_i_addr;
                cur_we = cur_d ? p_d_we : 1'b0;
                cur_wdata = p_d_wdata;
                cur_valid = 1; cur_abort = 0;
                wait_left = $urandom_range(0, 3);
            end
            if (cur_valid) begin
                checks++; if ({bus.mem_we, bus.mem_addr} !== {cur_we, cur_addr} || (cur_we && bus.mem_wdata !== cur_wdata)) begin
                    failures++; $display("FAIL rnd_n%0d access got=%0h required=%0h", n, {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {cur_we, cur_addr, cur_wdata});
                end
            end
            flush = 0; abandon = 0;
            if (cur_valid && !cur_d && $urandom_range(0, 9) == 0) begin
                flush = 1; abandon = 1; cur_abort = 1; i_pend = 0;
            end else if (!(cur_valid && !cur_d) && $urandom_range(0, 15) == 0) begin
                flush = 1;
            end
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
            if (cur_valid) begin
                if (wait_left == 0) begin
                    bus.mem_ack = 1'b1;
                    if (cur_we) mem_model[cur_addr[5:2]] = cur_wdata;
                    else bus.mem_rdata = mem_model[cur_addr[5:2]];
                    if (cur_d) begin
                        exp_dd = 1;
                        if (!cur_we) exp_d_rdata = mem_model[cur_addr[5:2]];
                    end else if (!cur_abort) begin
                        exp_id = 1;
                        exp_i_rdata = mem_model[cur_addr[5:2]];
                    end
                    cur_valid = 0;
                end else begin
                    wait_left--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.mem_ack = 1'b1;
            end
            bus.i_flush = flush;
            if (abandon) begin
                bus.i_req = 1'b0;
            end else if (!now_id && !i_pend) begin
                if (n < 600 && $urandom_range(0, 1) == 1) begin
                    bus.i_req = 1'b1; bus.i_addr = $urandom_range(0, 15) << 2; i_pend = 1;
                end else begin
                    bus.i_req = 1'b0;
                end
            end
            if (!now_dd && !d_pend) begin
                if (n < 600 && $urandom_range(0, 1) == 1) begin
                    bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                    bus.d_addr = $urandom_range(0, 15) << 2; bus.d_wdata = $urandom; d_pend = 1;
                end else begin
                    bus.d_req = 1'b0;
                end
            end else if (d_pend && cur_valid && cur_d) begin
                bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = ~bus.d_we;
            end
            p_i_elig = bus.i_req && !now_id; p_i_addr = bus.i_addr;
            p_d_elig = bus.d_req && !now_dd; p_d_addr = bus.d_addr;
            p_d_we = bus.d_we; p_d_wdata = bus.d_wdata;
            exp_req = cur_valid || (!exp_req && (p_i_elig || p_d_elig));
            #1;
            checks++; if ({bus.stall_if, bus.stall_mem} !== {p_i_elig, p_d_elig}) begin
                failures++; $display("FAIL rnd_n%0d stall got=%b required=%b", n, {bus.stall_if, bus.stall_mem}, {p_i_elig, p_d_elig});
            end
            n++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store_wait3();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        test_stray_ack();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "time limit");
    end
endmodule
